// File: rtl/fir_decim_ctrl_if.sv
// Sample-stream, delay-RAM, coefficient and MAC signals of the FIR decimator sequencer.
interface fir_decim_ctrl_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 32
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_di;
  logic [ADDR_W-1:0] ram_raddr;
  logic [ADDR_W-1:0] coef_addr;
  logic              mac_en;
  logic              mac_first;
  logic              mac_last;

  // Controller side
  modport master (
    input  in_valid, in_data,
    output in_ready, ram_we, ram_waddr, ram_di, ram_raddr, coef_addr,
    output mac_en, mac_first, mac_last
  );

  // Upstream source / RAM / MAC side
  modport slave (
    output in_valid, in_data,
    input  in_ready, ram_we, ram_waddr, ram_di, ram_raddr, coef_addr,
    input  mac_en, mac_first, mac_last
  );
endinterface

// File: rtl/fir_decim_ctrl.sv
// Decimating FIR sequencer: writes samples into the circular delay RAM and,
// every DECIM-th sample, scans TAPS entries newest-first with lockstep
// coefficient addresses and RAM-latency-aligned MAC enables.
module fir_decim_ctrl #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAPS   = 128,
  parameter int unsigned DECIM  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  fir_decim_ctrl_if.master      bus,
  output logic                  busy
);

  localparam int unsigned PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PH_W-1:0]   PH_LAST = PH_W'(DECIM - 1);
  localparam logic [ADDR_W-1:0] K_LAST  = ADDR_W'(TAPS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] wptr_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] k_q;
  logic [PH_W-1:0]   ph_q;
  logic              mac_en_q, mac_first_q, mac_last_q;
  logic              accept, trigger, in_run, k_last;

  // Handshake and trigger decode
  always_comb begin
    bus.in_ready = (state_q == S_IDLE) & ~clear;
    accept       = bus.in_valid & bus.in_ready;
    trigger      = accept & (ph_q == PH_LAST);
    in_run       = (state_q == S_RUN);
    k_last       = (k_q == K_LAST);
  end

  // RAM/ROM addressing and status; write gated off while reset is asserted
  always_comb begin
    bus.ram_we    = accept & ~reset;
    bus.ram_waddr = wptr_q;
    bus.ram_di    = bus.in_data;
    bus.ram_raddr = base_q - k_q;
    bus.coef_addr = k_q;
    bus.mac_en    = mac_en_q;
    bus.mac_first = mac_first_q;
    bus.mac_last  = mac_last_q;
    busy          = (state_q != S_IDLE);
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; clear overrides every transition
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (trigger) state_d = S_RUN;
        S_RUN:   if (k_last)  state_d = S_DRAIN;
        S_DRAIN: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Write pointer, decimation phase, scan base and tap counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      ph_q   <= '0;
      base_q <= '0;
      k_q    <= '0;
    end else if (clear) begin
      wptr_q <= '0;
      ph_q   <= '0;
      base_q <= '0;
      k_q    <= '0;
    end else begin
      if (accept) begin
        wptr_q <= wptr_q + ADDR_W'(1);
        ph_q   <= (ph_q == PH_LAST) ? '0 : ph_q + PH_W'(1);
      end
      if (trigger) base_q <= wptr_q;
      if (in_run && !k_last) k_q <= k_q + ADDR_W'(1);
      else                   k_q <= '0;
    end
  end

  // MAC strobes delayed one cycle to line up with registered RAM read data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mac_en_q    <= 1'b0;
      mac_first_q <= 1'b0;
      mac_last_q  <= 1'b0;
    end else if (clear) begin
      mac_en_q    <= 1'b0;
      mac_first_q <= 1'b0;
      mac_last_q  <= 1'b0;
    end else begin
      mac_en_q    <= in_run;
      mac_first_q <= in_run & (k_q == '0);
      mac_last_q  <= in_run & k_last;
    end
  end

endmodule

// File: tb/tb_fir_decim_ctrl.sv
// Directed bench for fir_decim_ctrl with ADDR_W=4, TAPS=8, DECIM=4.
module tb_fir_decim_ctrl;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAPS   = 8;
  localparam int unsigned DECIM  = 4;

  logic clk = 1'b0;
  logic reset;
  logic clear;
  logic busy;
  int   n_checks = 0;
  int   n_fail   = 0;

  fir_decim_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fir_decim_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAPS(TAPS), .DECIM(DECIM)) dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    reset = 1'b1; clear = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  // Push n samples unconditionally (caller knows the controller is idle)
  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DATA_W'(i + 1);
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset;
    logic [5:0] ctl;
    reset = 1'b1; clear = 1'b0; bus.in_valid = 1'b1; bus.in_data = 32'h55;
    repeat (2) @(posedge clk);
    @(negedge clk);
    ctl = {bus.in_ready, bus.ram_we, busy, bus.mac_en, bus.mac_first, bus.mac_last};
    n_checks++;
    if (ctl !== 6'b100000) begin
      n_fail++; $display("FAIL reset_held ctl: got %b want %b", ctl, 6'b100000);
    end
    reset = 1'b0; bus.in_valid = 1'b0;
    tick();
    @(negedge clk);
    ctl = {bus.in_ready, bus.ram_we, busy, bus.mac_en, bus.mac_first, bus.mac_last};
    n_checks++;
    if (ctl !== 6'b100000) begin
      n_fail++; $display("FAIL reset_released ctl: got %b want %b", ctl, 6'b100000);
    end
    n_checks++;
    if (bus.ram_raddr !== 4'd0 || bus.coef_addr !== 4'd0 || bus.ram_waddr !== 4'd0) begin
      n_fail++; $display("FAIL reset_addr: raddr %0d coef %0d waddr %0d want 0 0 0",
                         bus.ram_raddr, bus.coef_addr, bus.ram_waddr);
    end
    tick();
  endtask

  task automatic test_basic;
    logic [5:0] ctl, exp_ctl;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DATA_W'(i + 1);
      @(negedge clk);
      n_checks++;
      if ({bus.in_ready, bus.ram_we, busy} !== 3'b110 || bus.ram_waddr !== ADDR_W'(i) ||
          bus.ram_di !== DATA_W'(i + 1)) begin
        n_fail++; $display("FAIL basic_write%0d: rdy/we/busy %b waddr %0d di %0d want 110 %0d %0d",
                           i, {bus.in_ready, bus.ram_we, busy}, bus.ram_waddr, bus.ram_di, i, i + 1);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      exp_ctl = {(j == 9), 1'b0, (j <= 8), (j >= 1 && j <= 8), (j == 1), (j == 8)};
      ctl = {bus.in_ready, bus.ram_we, busy, bus.mac_en, bus.mac_first, bus.mac_last};
      n_checks++;
      if (ctl !== exp_ctl) begin
        n_fail++; $display("FAIL basic_ctl T+%0d: got %b want %b", j + 1, ctl, exp_ctl);
      end
      if (j < 8) begin
        n_checks++;
        if (bus.ram_raddr !== ADDR_W'(3 - j) || bus.coef_addr !== ADDR_W'(j)) begin
          n_fail++; $display("FAIL basic_addr k=%0d: raddr %0d coef %0d want %0d %0d",
                             j, bus.ram_raddr, bus.coef_addr, ADDR_W'(3 - j), j);
        end
      end
      tick();
    end
  endtask

  task automatic test_wrap;
    int acc = 0;
    int cycles = 0;
    apply_reset();
    bus.in_valid = 1'b1;
    while (acc < 20 && cycles < 200) begin
      bus.in_data = DATA_W'(acc + 1);
      @(negedge clk);
      n_checks++;
      if (bus.in_ready) begin
        if (bus.ram_we !== 1'b1 || bus.ram_waddr !== ADDR_W'(acc) || bus.ram_di !== DATA_W'(acc + 1)) begin
          n_fail++; $display("FAIL wrap_write%0d: we %b waddr %0d di %0d want 1 %0d %0d",
                             acc, bus.ram_we, bus.ram_waddr, bus.ram_di, ADDR_W'(acc), acc + 1);
        end
        acc++;
      end else if (bus.ram_we !== 1'b0) begin
        n_fail++; $display("FAIL wrap_we_blocked: got %b want 0", bus.ram_we);
      end
      cycles++;
      tick();
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (acc != 20) begin
      n_fail++; $display("FAIL wrap_timeout: accepted %0d want 20", acc);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.ram_raddr !== ADDR_W'(3 - k) || bus.coef_addr !== ADDR_W'(k) || busy !== 1'b1) begin
        n_fail++; $display("FAIL wrap_scan k=%0d: raddr %0d coef %0d busy %b want %0d %0d 1",
                           k, bus.ram_raddr, bus.coef_addr, busy, ADDR_W'(3 - k), k);
      end
      tick();
    end
    repeat (4) tick();
  endtask

  task automatic test_backpressure;
    int writes = 0;
    int j = 0;
    bit seen = 1'b0;
    apply_reset();
    feed(4);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hAA;
    while (!seen && j < 20) begin
      @(negedge clk);
      n_checks++;
      if (bus.ram_we) begin
        writes++;
        seen = 1'b1;
        if (bus.ram_waddr !== 4'd4 || bus.ram_di !== 32'hAA || j != 9) begin
          n_fail++; $display("FAIL bp_write: waddr %0d di %h at T+%0d want 4 aa T+10",
                             bus.ram_waddr, bus.ram_di, j + 1);
        end
      end else if (bus.in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_ready_no_we T+%0d: in_ready %b ram_we 0 want ready 0", j + 1, bus.in_ready);
      end
      j++;
      tick();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (writes != 1 || bus.ram_we !== 1'b0) begin
      n_fail++; $display("FAIL bp_count: writes %0d we %b want 1 0", writes, bus.ram_we);
    end
    tick();
  endtask

  task automatic test_clear;
    logic [4:0] ctl;
    apply_reset();
    feed(4);
    repeat (3) tick();
    clear = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.coef_addr !== 4'd3 || busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL clr_at_k3: coef %0d busy %b rdy %b want 3 1 0",
                         bus.coef_addr, busy, bus.in_ready);
    end
    tick();
    clear = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      ctl = {bus.in_ready, busy, bus.mac_en, bus.mac_first, bus.mac_last};
      n_checks++;
      if (ctl !== 5'b10000 || bus.ram_raddr !== 4'd0 || bus.coef_addr !== 4'd0) begin
        n_fail++; $display("FAIL clr_after c%0d: ctl %b raddr %0d coef %0d want 10000 0 0",
                           c, ctl, bus.ram_raddr, bus.coef_addr);
      end
      tick();
    end
    // clear coinciding with what would be the trigger sample
    feed(3);
    clear = 1'b1; bus.in_valid = 1'b1; bus.in_data = 32'h77;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.ram_we !== 1'b0) begin
      n_fail++; $display("FAIL clr_vs_trigger: rdy %b we %b want 0 0", bus.in_ready, bus.ram_we);
    end
    tick();
    clear = 1'b0; bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DATA_W'(i + 100);
      @(negedge clk);
      n_checks++;
      if (bus.ram_we !== 1'b1 || bus.ram_waddr !== ADDR_W'(i) || busy !== 1'b0) begin
        n_fail++; $display("FAIL clr_restart%0d: we %b waddr %0d busy %b want 1 %0d 0",
                           i, bus.ram_we, bus.ram_waddr, busy, i);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL clr_retrigger: busy %b want 1", busy);
    end
    repeat (12) tick();
  endtask

  task automatic test_reset_mid_drain;
    logic [5:0] ctl;
    apply_reset();
    feed(4);
    repeat (8) tick();
    ctl = {bus.in_ready, bus.ram_we, busy, bus.mac_en, bus.mac_first, bus.mac_last};
    n_checks++;
    if (ctl !== 6'b001101) begin
      n_fail++; $display("FAIL drain_state: ctl %b want 001101", ctl);
    end
    reset = 1'b1;
    #1;
    ctl = {bus.in_ready, bus.ram_we, busy, bus.mac_en, bus.mac_first, bus.mac_last};
    n_checks++;
    if (ctl !== 6'b100000 || bus.ram_raddr !== 4'd0 || bus.coef_addr !== 4'd0 || bus.ram_waddr !== 4'd0) begin
      n_fail++; $display("FAIL drain_async_reset: ctl %b raddr %0d coef %0d waddr %0d want 100000 0 0 0",
                         ctl, bus.ram_raddr, bus.coef_addr, bus.ram_waddr);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    test_basic();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_clear();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
